uart_frame_parser: RTL and testbench

Byte-stream consumer sitting directly downstream of the UART receiver; takes each received byte plus its one-cycle ready strobe and assembles framed commands. Frame format: SYNC (0xAA), CMD, LEN, LEN payload bytes, CHK, where CHK is the XOR of CMD, LEN and all payload bytes. Emits a one-cycle frame_valid with latched command, length and payload, or a one-cycle frame_error with a cause code. Feeds the LED/register logic in the top level in place of the raw byte path.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_idle_timer.sv | 30 +++
 rtl/uart_frame_parser.sv | 136 +++++++++++++
 tb/tb_uart_frame_parser.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART frame parser: FSM states, error cause codes
// and the frame sync marker.
package uart_pkg;

  // Frame assembly states, in the order bytes arrive on the wire
  typedef enum logic [2:0] {
    S_SYNC,
    S_CMD,
    S_LEN,
    S_PAY,
    S_CHK
  } state_t;

  // Cause codes reported on error_code; ERR_NONE only appears after reset
  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    LEN_ERR  = 2'd1,
    CHK_ERR  = 2'd2,
    TO_ERR   = 2'd3
  } err_t;

  localparam logic [7:0] SYNC_BYTE = 8'hAA;

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer for the frame parser. Counts cycles while a frame
// is in progress, restarts on every received byte and gives a one-cycle
// expiry pulse when TIMEOUT_CLKS consecutive idle cycles have elapsed.
module uart_idle_timer
  #(parameter int TIMEOUT_CLKS = 52083)
  (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    output logic expired
  );

  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

  logic [CNT_W-1:0] count;

  // Expiry fires on the TIMEOUT_CLKS-th idle cycle; a byte in the same cycle wins
  assign expired = active && !clear && (count == CNT_W'(TIMEOUT_CLKS - 1));

  // Idle counter: held at zero when idle or on a byte, restarts after expiry
  always_ff @(posedge clk) begin
    if (rst || !active || clear || expired) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// UART frame parser: assembles SYNC(0xAA) CMD LEN payload CHK frames from
// the receiver byte strobe and reports good frames or discarded frames.
// CHK is the XOR of CMD, LEN and every payload byte.
// Optional inter-byte timeout is enabled with the macro PARSER_TIMEOUT_EN.
module uart_frame_parser
  import uart_pkg::*;
  #(
    parameter int MAX_PAYLOAD  = 8,
    parameter int TIMEOUT_CLKS = 52083
  )
  (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_valid,
    output logic                             frame_valid,
    output logic [7:0]                       frame_cmd,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0] frame_len,
    output logic [MAX_PAYLOAD*8-1:0]         frame_payload,
    output logic                             frame_error,
    output logic [1:0]                       error_code,
    output logic                             busy
  );

  localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);

  state_t                   state;
  logic [7:0]               cmd_r;
  logic [LEN_W-1:0]         len_r;
  logic [LEN_W-1:0]         idx;
  logic [7:0]               chk;
  logic [MAX_PAYLOAD*8-1:0] pay_buf;
  logic                     timeout_hit;

`ifdef PARSER_TIMEOUT_EN
  uart_idle_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (busy),
    .clear   (rx_valid),
    .expired (timeout_hit)
  );
`else
  // No timer: a partial frame waits forever; this is constant-false for any legal TIMEOUT_CLKS
  assign timeout_hit = (TIMEOUT_CLKS < 0);
`endif

  // Frame FSM with registered outputs; advances only on byte strobes or a timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_SYNC;
      cmd_r         <= '0;
      len_r         <= '0;
      idx           <= '0;
      chk           <= '0;
      pay_buf       <= '0;
      frame_valid   <= 1'b0;
      frame_error   <= 1'b0;
      frame_cmd     <= '0;
      frame_len     <= '0;
      frame_payload <= '0;
      error_code    <= ERR_NONE;
      busy          <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      if (timeout_hit) begin
        state       <= S_SYNC;
        busy        <= 1'b0;
        frame_error <= 1'b1;
        error_code  <= TO_ERR;
      end else if (rx_valid) begin
        case (state)
          S_SYNC: begin
            if (rx_data == SYNC_BYTE) begin
              state <= S_CMD;
              busy  <= 1'b1;
            end
          end
          S_CMD: begin
            cmd_r <= rx_data;
            chk   <= rx_data;
            state <= S_LEN;
          end
          S_LEN: begin
            if (rx_data > 8'(MAX_PAYLOAD)) begin
              frame_error <= 1'b1;
              error_code  <= LEN_ERR;
              state       <= S_SYNC;
              busy        <= 1'b0;
            end else begin
              len_r <= rx_data[LEN_W-1:0];
              chk   <= chk ^ rx_data;
              idx   <= '0;
              state <= (rx_data == 8'h00) ? S_CHK : S_PAY;
            end
          end
          S_PAY: begin
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
              if (idx == LEN_W'(i)) begin
                pay_buf[i*8 +: 8] <= rx_data;
              end
            end
            chk <= chk ^ rx_data;
            if (idx == len_r - LEN_W'(1)) begin
              state <= S_CHK;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
          S_CHK: begin
            if (rx_data == chk) begin
              frame_valid <= 1'b1;
              frame_cmd   <= cmd_r;
              frame_len   <= len_r;
              // Buffer slots beyond LEN may hold stale bytes from an older frame
              for (int i = 0; i < MAX_PAYLOAD; i++) begin
                frame_payload[i*8 +: 8] <= (LEN_W'(i) < len_r) ? pay_buf[i*8 +: 8] : 8'h00;
              end
            end else begin
              frame_error <= 1'b1;
              error_code  <= CHK_ERR;
            end
            state <= S_SYNC;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_SYNC;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser. Expected frame events are
// queued before the bytes are driven; a negedge monitor pops and compares
// them whenever the DUT pulses frame_valid or frame_error.
// Timeout checks follow PARSER_TIMEOUT_EN the same way the design does.
module tb_uart_frame_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_valid;
  logic [7:0]  frame_cmd;
  logic [3:0]  frame_len;
  logic [63:0] frame_payload;
  logic        frame_error;
  logic [1:0]  error_code;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_err;
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [63:0] pay;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];

  logic [7:0]  model_cmd;
  logic [3:0]  model_len;
  logic [63:0] model_pay;
  logic [1:0]  model_code;

  uart_frame_parser #(.MAX_PAYLOAD(8), .TIMEOUT_CLKS(100)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .frame_valid   (frame_valid),
    .frame_cmd     (frame_cmd),
    .frame_len     (frame_len),
    .frame_payload (frame_payload),
    .frame_error   (frame_error),
    .error_code    (error_code),
    .busy          (busy)
  );

  // 100 MHz bench clock
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=stall expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drive one byte strobe; consecutive calls give back-to-back bytes
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic expectValid(input logic [7:0] c, input logic [3:0] l, input logic [63:0] p);
    model_cmd = c;
    model_len = l;
    model_pay = p;
    sb.push_back('{1'b0, c, l, p, model_code});
  endtask

  task automatic expectError(input logic [1:0] code);
    model_code = code;
    sb.push_back('{1'b1, model_cmd, model_len, model_pay, code});
  endtask

  task automatic waitDrain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_valid"}, 64'(frame_valid), 64'd0);
    checkOutput({tag, "_error"}, 64'(frame_error), 64'd0);
    checkOutput({tag, "_cmd"}, 64'(frame_cmd), 64'd0);
    checkOutput({tag, "_len"}, 64'(frame_len), 64'd0);
    checkOutput({tag, "_pay"}, frame_payload, 64'd0);
    checkOutput({tag, "_code"}, 64'(error_code), 64'd0);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (frame_valid || frame_error)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_event", {62'd0, frame_valid, frame_error}, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("evt_error", 64'(frame_error), 64'(e.is_err));
        checkOutput("evt_valid", 64'(frame_valid), 64'(!e.is_err));
        checkOutput("evt_cmd", 64'(frame_cmd), 64'(e.cmd));
        checkOutput("evt_len", 64'(frame_len), 64'(e.len));
        checkOutput("evt_pay", frame_payload, e.pay);
        checkOutput("evt_code", 64'(error_code), 64'(e.code));
      end
    end
  end

  initial begin
    logic [7:0]  pbytes [8];
    logic [63:0] ppack;
    logic [7:0]  pchk;

    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    model_cmd  = '0;
    model_len  = '0;
    model_pay  = '0;
    model_code = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;

    $display("[TB] good frame");
    expectValid(8'h01, 4'd2, 64'h2010);
    applyStimulus(8'hAA); applyStimulus(8'h01); applyStimulus(8'h02);
    applyStimulus(8'h10); applyStimulus(8'h20); applyStimulus(8'h33);
    waitDrain("good_drain", 20);
    checkOutput("good_busy", 64'(busy), 64'd0);

    $display("[TB] bad checksum");
    expectError(2'd2);
    applyStimulus(8'hAA); applyStimulus(8'h01); applyStimulus(8'h02);
    applyStimulus(8'h10); applyStimulus(8'h20); applyStimulus(8'h34);
    waitDrain("chk_drain", 20);

    $display("[TB] length limit then zero-length frame");
    expectError(2'd1);
    expectValid(8'h05, 4'd0, 64'h0);
    applyStimulus(8'hAA); applyStimulus(8'h07); applyStimulus(8'h09);
    applyStimulus(8'hAA); applyStimulus(8'h05); applyStimulus(8'h00); applyStimulus(8'h05);
    waitDrain("len_drain", 20);

    $display("[TB] full-length frame with embedded sync byte, next frame back-to-back");
    pchk = 8'h0C ^ 8'h08;
    ppack = '0;
    for (int i = 0; i < 8; i++) begin
      pbytes[i] = (i == 2) ? 8'hAA : 8'(8'h11 * (i + 1));
      pchk ^= pbytes[i];
      ppack[i*8 +: 8] = pbytes[i];
    end
    expectValid(8'h0C, 4'd8, ppack);
    expectValid(8'h06, 4'd1, 64'h7E);
    applyStimulus(8'hAA); applyStimulus(8'h0C); applyStimulus(8'h08);
    for (int i = 0; i < 8; i++) applyStimulus(pbytes[i]);
    applyStimulus(pchk);
    applyStimulus(8'hAA); applyStimulus(8'h06); applyStimulus(8'h01);
    applyStimulus(8'h7E); applyStimulus(8'h79);
    waitDrain("full_drain", 20);

    $display("[TB] garbage then frame");
    expectValid(8'h03, 4'd1, 64'h7E);
    applyStimulus(8'h55); applyStimulus(8'hFF); applyStimulus(8'h00);
    applyStimulus(8'hAA); applyStimulus(8'h03); applyStimulus(8'h01);
    applyStimulus(8'h7E); applyStimulus(8'h7C);
    waitDrain("garbage_drain", 20);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hAA); applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h10);
    checkOutput("mid_busy", 64'(busy), 64'd1);
    rst      = 1'b1;
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    model_cmd  = '0;
    model_len  = '0;
    model_pay  = '0;
    model_code = '0;
    checkResetState("midrst");
    expectValid(8'h02, 4'd1, 64'h55);
    applyStimulus(8'hAA); applyStimulus(8'h02); applyStimulus(8'h01);
    applyStimulus(8'h55); applyStimulus(8'h56);
    waitDrain("midrst_drain", 20);

    $display("[TB] idle partial frame");
`ifdef PARSER_TIMEOUT_EN
    expectError(2'd3);
    applyStimulus(8'hAA); applyStimulus(8'h01);
    waitDrain("timeout_drain", 200);
    checkOutput("timeout_busy", 64'(busy), 64'd0);
`else
    applyStimulus(8'hAA); applyStimulus(8'h01);
    repeat (150) @(posedge clk);
    #1;
    checkOutput("noto_busy", 64'(busy), 64'd1);
    checkOutput("noto_code", 64'(error_code), 64'(model_code));
`endif
    checkOutput("final_queue", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
